// File: rtl/serial_checking_sink_pkg.sv
// rtl/serial_checking_sink_pkg.sv - shared flit geometry and sink state encoding
// Field offsets are shared with the serial traffic source so both agree on layout.
package serial_checking_sink_pkg;
    localparam int ADDR_SZ   = 4;
    localparam int NUM_NODES = 16;
    localparam int SEQ_SZ    = 8;
    localparam int FW        = 2 * ADDR_SZ + SEQ_SZ;
    localparam int SEQ_LSB   = 0;
    localparam int SRC_LSB   = SEQ_LSB + SEQ_SZ;
    localparam int DEST_LSB  = SRC_LSB + ADDR_SZ;
    localparam int PKT_CNT_W = 20;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_HOLD
    } sink_state_t;
endpackage

// File: rtl/serial_checking_sink_if.sv
// rtl/serial_checking_sink_if.sv - one-bit serial data/busy link
// The master drives flits onto data; the slave throttles it with busy.
interface serial_checking_sink_if;
    logic data;
    logic busy;

    modport master (output data, input busy);
    modport slave  (input data, output busy);
endinterface

// File: rtl/serial_checking_sink_lfsr8.sv
// rtl/serial_checking_sink_lfsr8.sv - 8-bit maximal LFSR, x^8+x^6+x^5+x^4+1
// A zero seed is remapped so the register can never lock up at zero.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] value
);
    localparam logic [7:0] START = (SEED == 8'h00) ? 8'h01 : SEED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= START;
        end else if (en) begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end
endmodule

// File: rtl/serial_checking_sink.sv
// rtl/serial_checking_sink.sv - checking serial sink for a mesh router local port
// Deserializes flits, checks dest and per-source sequence, and applies random backpressure.
module serial_checking_sink
    import serial_checking_sink_pkg::sink_state_t,
           serial_checking_sink_pkg::ST_IDLE,
           serial_checking_sink_pkg::ST_SHIFT,
           serial_checking_sink_pkg::ST_CHECK,
           serial_checking_sink_pkg::ST_HOLD;
#(
    parameter int ID        = 0,
    parameter int HOSP      = 255,
    parameter int NUM_NODES = serial_checking_sink_pkg::NUM_NODES,
    parameter int ADDR_SZ   = serial_checking_sink_pkg::ADDR_SZ,
    parameter int SEQ_SZ    = serial_checking_sink_pkg::SEQ_SZ,
    localparam int FLIT_W   = 2 * ADDR_SZ + SEQ_SZ
) (
    input  logic                       clk,
    input  logic                       reset,
    serial_checking_sink_if.slave      lnk,
    output logic [FLIT_W-1:0]          flit_out,
    output logic                       flit_valid,
    output logic [19:0]                pkt_count,
    output logic [15:0]                dest_err_count,
    output logic [15:0]                seq_err_count
);
    localparam int CNT_W = $clog2(FLIT_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FLIT_W - 1);
    localparam logic [ADDR_SZ-1:0] MY_ID = ADDR_SZ'(ID);
    localparam logic [8:0] HOSP9 = 9'(HOSP);
    localparam bit ALL_TRACKED = NUM_NODES >= (1 << ADDR_SZ);
    localparam logic [ADDR_SZ:0] NODES_EXT = (ADDR_SZ + 1)'(NUM_NODES);

    sink_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [FLIT_W-1:0] shreg_q;
    logic [7:0]        lfsr_val;
    logic              busy_c;
    logic [19:0]       pkt_cnt_q;
    logic [15:0]       dest_cnt_q;
    logic [15:0]       seq_cnt_q;
    logic [SEQ_SZ-1:0] exp_seq [NUM_NODES];

    logic [SEQ_SZ-1:0]  f_seq;
    logic [ADDR_SZ-1:0] f_src;
    logic [ADDR_SZ-1:0] f_dest;
    logic               src_ok;

    assign f_seq  = flit_out[SEQ_SZ-1:0];
    assign f_src  = flit_out[SEQ_SZ +: ADDR_SZ];
    assign f_dest = flit_out[SEQ_SZ + ADDR_SZ +: ADDR_SZ];
    assign src_ok = ALL_TRACKED || ({1'b0, f_src} < NODES_EXT);

    lfsr8 #(.SEED(8'hA5 ^ 8'(ID))) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .value (lfsr_val)
    );

    always_comb begin
        state_d    = state_q;
        busy_c     = 1'b1;
        flit_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (lnk.data) state_d = ST_SHIFT;
            end
            ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_CHECK;
            ST_CHECK: begin
                flit_valid = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD:  if ({1'b0, lfsr_val} <= HOSP9) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign lnk.busy       = busy_c;
    assign pkt_count      = pkt_cnt_q;
    assign dest_err_count = dest_cnt_q;
    assign seq_err_count  = seq_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            flit_out   <= '0;
            pkt_cnt_q  <= '0;
            dest_cnt_q <= '0;
            seq_cnt_q  <= '0;
            for (int i = 0; i < NUM_NODES; i++) exp_seq[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (lnk.data) cnt_q <= '0;
                ST_SHIFT: begin
                    shreg_q[cnt_q] <= lnk.data;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) flit_out <= {lnk.data, shreg_q[FLIT_W-2:0]};
                end
                ST_CHECK: begin
                    if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
                    if (f_dest != MY_ID && dest_cnt_q != '1) dest_cnt_q <= dest_cnt_q + 1'b1;
                    // Untracked sources always count as a sequence error and leave the table alone.
                    if ((!src_ok || f_seq != exp_seq[f_src]) && seq_cnt_q != '1)
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    if (src_ok) exp_seq[f_src] <= f_seq + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_checking_sink.sv
// tb/tb_serial_checking_sink.sv - self-checking bench for serial_checking_sink
// Three sinks (HOSP 255, 0, 128) share one clock and are checked against a rule-level model.
module tb_serial_checking_sink;
    logic        clk;
    logic [2:0]  rst;
    logic [15:0] fo [3];
    logic [2:0]  fv;
    logic [19:0] pc [3];
    logic [15:0] dc [3];
    logic [15:0] sc [3];

    int checks = 0;
    int passes = 0;

    int          m_pkt  [3];
    int          m_dest [3];
    int          m_seq  [3];
    logic [7:0]  m_exp  [3][16];

    serial_checking_sink_if l0 ();
    serial_checking_sink_if l1 ();
    serial_checking_sink_if l2 ();

    serial_checking_sink #(.ID(5), .HOSP(255)) u0 (
        .clk(clk), .reset(rst[0]), .lnk(l0), .flit_out(fo[0]), .flit_valid(fv[0]),
        .pkt_count(pc[0]), .dest_err_count(dc[0]), .seq_err_count(sc[0]));
    serial_checking_sink #(.ID(5), .HOSP(0)) u1 (
        .clk(clk), .reset(rst[1]), .lnk(l1), .flit_out(fo[1]), .flit_valid(fv[1]),
        .pkt_count(pc[1]), .dest_err_count(dc[1]), .seq_err_count(sc[1]));
    serial_checking_sink #(.ID(5), .HOSP(128)) u2 (
        .clk(clk), .reset(rst[2]), .lnk(l2), .flit_out(fo[2]), .flit_valid(fv[2]),
        .pkt_count(pc[2]), .dest_err_count(dc[2]), .seq_err_count(sc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic busy_of(input int k);
        case (k)
            0:       return l0.busy;
            1:       return l1.busy;
            default: return l2.busy;
        endcase
    endfunction

    task automatic set_data(input int k, input logic v);
        case (k)
            0:       l0.data = v;
            1:       l1.data = v;
            default: l2.data = v;
        endcase
    endtask

    task automatic model_reset(input int k);
        m_pkt[k] = 0; m_dest[k] = 0; m_seq[k] = 0;
        for (int i = 0; i < 16; i++) m_exp[k][i] = 8'h00;
    endtask

    task automatic model_rx(input int k, input logic [15:0] f);
        logic [3:0] d, s;
        logic [7:0] q;
        d = f[15:12]; s = f[11:8]; q = f[7:0];
        if (m_pkt[k] < 20'hFFFFF) m_pkt[k]++;
        if (d != 4'd5 && m_dest[k] < 16'hFFFF) m_dest[k]++;
        if (q != m_exp[k][s] && m_seq[k] < 16'hFFFF) m_seq[k]++;
        m_exp[k][s] = q + 8'd1;
    endtask

    task automatic do_reset(input int k);
        set_data(k, 1'b0);
        @(negedge clk); rst[k] = 1'b1;
        @(negedge clk); rst[k] = 1'b0;
        model_reset(k);
    endtask

    // Returns at the negedge of the cycle after the last data bit was sampled.
    task automatic send(input int k, input logic [15:0] f, output bit early, output bit valid_now);
        int n;
        n = 0;
        early = 1'b0;
        while (busy_of(k) && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) check("idle_wait", 32'(n), 32'd0);
        set_data(k, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (fv[k]) early = 1'b1;
            set_data(k, f[i]);
        end
        @(negedge clk);
        set_data(k, 1'b0);
        valid_now = fv[k];
        model_rx(k, f);
    endtask

    task automatic wait_idle(input int k, output int cyc);
        cyc = 16;
        while (busy_of(k) && cyc < 5000) begin cyc++; @(negedge clk); end
        if (cyc >= 5000) check("busy_release", 32'(cyc), 32'd0);
    endtask

    initial begin
        bit          e, v, drop, extra;
        int          cyc, cmin, cmax;
        logic [15:0] f;
        logic [3:0]  s;
        logic [7:0]  q;

        rst = 3'b111;
        l0.data = 1'b0; l1.data = 1'b0; l2.data = 1'b0;
        for (int k = 0; k < 3; k++) model_reset(k);
        repeat (3) @(negedge clk);
        rst = 3'b000;

        check("rst_busy",  32'(l0.busy), 32'd0);
        check("rst_valid", 32'(fv[0]), 32'd0);
        check("rst_flit",  32'(fo[0]), 32'd0);
        check("rst_pkt",   32'(pc[0]), 32'd0);
        check("rst_dest",  32'(dc[0]), 32'd0);
        check("rst_seq",   32'(sc[0]), 32'd0);

        send(0, 16'h5300, e, v);
        check("clean_early_valid", 32'(e), 32'd0);
        check("clean_valid",       32'(v), 32'd1);
        check("clean_flit",        32'(fo[0]), 32'h5300);
        wait_idle(0, cyc);
        check("clean_busy_cycles", 32'(cyc), 32'd18);
        check("clean_pkt",  32'(pc[0]), 32'd1);
        check("clean_dest", 32'(dc[0]), 32'd0);
        check("clean_seq",  32'(sc[0]), 32'd0);

        do_reset(0);
        send(0, 16'h7300, e, v);
        send(0, 16'h5304, e, v);
        wait_idle(0, cyc);
        check("misroute_dest", 32'(dc[0]), 32'd1);
        check("misseq_seq",    32'(sc[0]), 32'd1);
        send(0, 16'h5305, e, v);
        wait_idle(0, cyc);
        check("resync_seq", 32'(sc[0]), 32'd1);
        check("resync_pkt", 32'(pc[0]), 32'd3);

        do_reset(0);
        for (int i = 0; i < 257; i++) begin
            send(0, {8'h52, 8'(i)}, e, v);
            if (i < 4) send(0, {8'h59, 8'(i)}, e, v);
        end
        wait_idle(0, cyc);
        check("wrap_pkt",  32'(pc[0]), 32'd261);
        check("wrap_seq",  32'(sc[0]), 32'd0);
        check("wrap_dest", 32'(dc[0]), 32'd0);

        for (int i = 0; i < 60; i++) begin
            s = 4'($urandom_range(0, 15));
            q = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_exp[0][s];
            f = {(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd5), s, q};
            send(0, f, e, v);
            check("rand_flit", 32'(fo[0]), 32'(f));
        end
        wait_idle(0, cyc);
        check("rand_pkt",  32'(pc[0]), 32'(m_pkt[0]));
        check("rand_dest", 32'(dc[0]), 32'(m_dest[0]));
        check("rand_seq",  32'(sc[0]), 32'(m_seq[0]));

        set_data(0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_data(0, 1'($urandom));
        end
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("midrst_busy", 32'(l0.busy), 32'd0);
        check("midrst_pkt",  32'(pc[0]), 32'd0);
        check("midrst_dest", 32'(dc[0]), 32'd0);
        check("midrst_seq",  32'(sc[0]), 32'd0);
        set_data(0, 1'b0);
        @(negedge clk);
        rst[0] = 1'b0;
        model_reset(0);
        send(0, 16'h5300, e, v);
        wait_idle(0, cyc);
        check("midrst_flit",    32'(fo[0]), 32'h5300);
        check("midrst_after_pkt", 32'(pc[0]), 32'd1);
        check("midrst_after_seq", 32'(sc[0]), 32'd0);

        @(negedge clk);
        force u0.pkt_cnt_q = 20'hFFFFE;
        @(negedge clk);
        release u0.pkt_cnt_q;
        m_pkt[0] = 20'hFFFFE;
        send(0, 16'h7300, e, v);
        send(0, 16'h7305, e, v);
        wait_idle(0, cyc);
        check("sat_pkt",  32'(pc[0]), 32'hFFFFF);
        check("sat_dest", 32'(dc[0]), 32'(m_dest[0]));
        check("sat_seq",  32'(sc[0]), 32'(m_seq[0]));

        send(1, 16'h5300, e, v);
        check("dead_flit", 32'(fo[1]), 32'h5300);
        drop = 1'b0; extra = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!l1.busy) drop = 1'b1;
            if (fv[1]) extra = 1'b1;
            set_data(1, 1'($urandom));
        end
        set_data(1, 1'b0);
        check("dead_busy_held", 32'(drop), 32'd0);
        check("dead_no_valid",  32'(extra), 32'd0);
        check("dead_pkt",       32'(pc[1]), 32'd1);

        cmin = 5000; cmax = 0;
        for (int i = 0; i < 500; i++) begin
            s = 4'($urandom_range(0, 15));
            q = ($urandom_range(0, 4) == 0) ? 8'($urandom) : m_exp[2][s];
            f = {4'd5, s, q};
            send(2, f, e, v);
            if (fo[2] !== f || !v) check("hosp_flit", 32'(fo[2]), 32'(f));
            wait_idle(2, cyc);
            if (cyc < cmin) cmin = cyc;
            if (cyc > cmax) cmax = cyc;
        end
        check("hosp_pkt",     32'(pc[2]), 32'd500);
        check("hosp_seq",     32'(sc[2]), 32'(m_seq[2]));
        check("hosp_dest",    32'(dc[2]), 32'd0);
        check("hosp_min_hold", 32'(cmin), 32'd18);
        check("hosp_varies",  32'(cmax > cmin), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/serial_checking_sink.md
Name: serial_checking_sink

Overview:
- Terminating endpoint for one router local port, placed in each mesh node beside the serial traffic source.
- Receives serial flits on the one-bit data/busy link, deserializes them, and checks destination and per-source sequence numbers.
- Applies pseudo-random backpressure and exports counters that the testbench reads at the end of a run.
- Replaces the plain sink in checking runs.

Parameters:
ID, 0, node index of this sink; the expected destination of every flit received here.
HOSP, 255, hospitality 0-255; higher values release busy sooner. 0 holds busy permanently (dead-sink congestion mode).
NUM_NODES, 16, number of sources tracked.
ADDR_SZ, 4, address field width.
SEQ_SZ, 8, sequence field width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
data  in  1  serial line from the router local output.
busy  out  1  backpressure to the router local output.
flit_out  out  2*ADDR_SZ+SEQ_SZ  last received flit.
flit_valid  out  1  one-cycle pulse when flit_out is updated.
pkt_count  out  20  flits received, saturating.
dest_err_count  out  16  flits whose dest is not ID, saturating.
seq_err_count  out  16  flits whose seq is not the expected value, saturating.

Behaviour:
- Flit layout, FW = 2*ADDR_SZ+SEQ_SZ (16 by default): [SEQ_SZ-1:0] seq, next ADDR_SZ bits src, top ADDR_SZ bits dest.
- Link protocol:
  - The line idles at 0.
  - The transmitter may drive a single start bit of 1 only in a cycle where busy=0.
  - The FW data bits follow on consecutive cycles, LSB first.
- Reset values:
  - busy, flit_out, flit_valid and all counters are 0.
  - State is IDLE and the expected-seq table is all 0.
  - lfsr = (8'hA5 ^ ID[7:0]); a seed of 0 is replaced by 8'h01.
- LFSR: 8-bit, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle out of reset and never holds 0.
- IDLE: busy=0. If data=1 at a clock edge, clear bit counter cnt and go to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge shifts data into a shift register at bit position cnt and increments cnt.
  - On the edge that samples bit FW-1, load flit_out and go to CHECK.
- CHECK:
  - busy=1, flit_valid=1 for exactly this cycle.
  - On exit edge, pkt_count += 1.
  - If dest != ID, dest_err_count += 1.
  - If seq != exp[src], seq_err_count += 1.
  - exp[src] <= seq+1 mod 2^SEQ_SZ. The table resyncs to the received value on error.
  - Go to HOLD.
- HOLD: busy=1. On an edge where lfsr <= HOSP (8-bit compare), go to IDLE; otherwise stay.
- Latency:
  - Start bit sampled at edge 0 → data bits at edges 1..FW → CHECK during cycle FW+1.
  - With HOSP=255, busy is high for FW+2 cycles and falls in cycle FW+3.
- busy is asserted in the cycle after the start-bit edge. The transmitter must not re-sample busy inside a flit.
- src >= NUM_NODES: count the flit, skip the seq check, do not write the table, increment seq_err_count.
- Saturation: every counter stops at its all-ones value; the other counters keep updating.
- Seq wrap: 255 followed by 0 is legal.
- data=1 during CHECK or HOLD is ignored. It is a protocol violation by the transmitter and is not counted.
- Reset asserted mid-SHIFT discards the partial flit; all state returns to reset values immediately.
- flit_out holds its last value until the next CHECK.

Decomposition:
- Shared constants file: ADDR_SZ, NUM_NODES, SEQ_SZ and the flit field offsets (SEQ_LSB, SRC_LSB, DEST_LSB).
- The serial transmitter and this sink both reference those constants.
- Sub-module lfsr8 (seed parameter, enable, 8-bit value out), reusable by the source's injection-rate logic.
- Deserializer, FSM, checker and counters stay in this module.

Test Plan:
- Clean flit: ID=5, HOSP=255, send dest=5 src=3 seq=0 (16'h5300) → flit_valid pulse in cycle 17, flit_out=16'h5300, pkt_count=1, both error counters 0, busy falls in cycle 19.
- Misrouted and missequenced: ID=5, send dest=7 src=3 seq=0, then dest=5 src=3 seq=4 → dest_err_count=1, seq_err_count=1; a following src=3 seq=5 flit adds no error.
- Sequence wrap and independent sources: src=2 seq 0..255 then 0, interleaved with src=9 seq 0..3 → pkt_count=261, seq_err_count=0.
- Backpressure:
  - HOSP=0: after the first flit, busy stays 1 for 1000 cycles and extra start bits are not counted.
  - HOSP=128: HOLD length varies per flit and no flit is lost over 500 flits.
- Reset mid-flit: assert reset after 7 data bits → busy=0 and counters 0 the same cycle; a complete flit after release is received correctly with expected seq 0.
- Saturation: force pkt_count near 20'hFFFFF (or run 2^20 flits) → pkt_count stays 20'hFFFFF and error counters still increment.
